// File: rtl/tone_synth.sv
// tone_synth: NUM_CH independent square-wave tone channels driven from the
// shared note table, mixed with a global volume into one PWM speaker output.
// Note changes take effect only on half-period boundaries so every
// half-period at a given pitch has full length.
module tone_synth #(
    parameter int NUM_CH      = 2,
    parameter int NOTE_W      = 5,
    parameter int NUM_NOTES   = 22,
    parameter int CNT_W       = 32,
    parameter int VOL_W       = 3,
    parameter int HP_OVERRIDE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*NOTE_W-1:0] note,
    input  logic [VOL_W-1:0]         vol,
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH-1:0]        active,
    output logic                     speaker
);

    // Full-scale mix level: every channel high at maximum volume.
    localparam int unsigned LMAX    = NUM_CH * ((1 << VOL_W) - 1);
    localparam int          LVL_W   = $clog2(LMAX + 1);
    localparam int unsigned NOTES_U = NUM_NOTES;

    // Half-period table in clk cycles (100 MHz clock), L1..H7 for codes 1..21.
    function automatic logic [CNT_W-1:0] table_hp(input logic [NOTE_W-1:0] n);
        logic [31:0] v;
        case (32'(n))
            1:       v = 32'd190839;  // L1
            2:       v = 32'd170068;  // L2
            3:       v = 32'd151515;  // L3
            4:       v = 32'd143266;  // L4
            5:       v = 32'd127551;  // L5
            6:       v = 32'd113636;  // L6
            7:       v = 32'd101214;  // L7
            8:       v = 32'd95602;   // M1
            9:       v = 32'd85178;   // M2
            10:      v = 32'd75872;   // M3
            11:      v = 32'd71633;   // M4
            12:      v = 32'd63775;   // M5
            13:      v = 32'd56818;   // M6
            14:      v = 32'd50607;   // M7
            15:      v = 32'd47755;   // H1
            16:      v = 32'd42553;   // H2
            17:      v = 32'd37907;   // H3
            18:      v = 32'd35790;   // H4
            19:      v = 32'd31887;   // H5
            20:      v = 32'd28409;   // H6
            21:      v = 32'd25303;   // H7
            default: v = 32'd0;
        endcase
        return CNT_W'(v);
    endfunction

    // Half-period of a note, never below one cycle.
    function automatic logic [CNT_W-1:0] half_period(input logic [NOTE_W-1:0] n);
        logic [CNT_W-1:0] hp;
        if (HP_OVERRIDE != 0)
            hp = CNT_W'(HP_OVERRIDE) * CNT_W'(n);
        else
            hp = table_hp(n);
        if (hp == '0)
            hp = CNT_W'(1);
        return hp;
    endfunction

    // Out-of-range codes play as rest.
    function automatic logic [NOTE_W-1:0] legal_note(input logic [NOTE_W-1:0] n);
        return (32'(n) < NOTES_U) ? n : '0;
    endfunction

    logic [NUM_CH-1:0] sq;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [NOTE_W-1:0] req;
        logic [NOTE_W-1:0] act_note;
        logic [CNT_W-1:0]  cnt;
        logic [CNT_W-1:0]  hp_last;
        logic              sq_r;
        logic              tick_r;

        assign req       = legal_note(note[k*NOTE_W +: NOTE_W]);
        assign hp_last   = half_period(act_note) - CNT_W'(1);
        assign sq[k]     = sq_r;
        assign tick[k]   = tick_r;
        assign active[k] = (act_note != '0);

        // Half-period counter; the requested note is only adopted while idle or at a boundary.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_note <= '0;
                cnt      <= '0;
                sq_r     <= 1'b0;
                tick_r   <= 1'b0;
            end else if (act_note == '0) begin
                cnt      <= '0;
                sq_r     <= 1'b0;
                tick_r   <= 1'b0;
                act_note <= req;
            end else if (cnt == hp_last) begin
                cnt      <= '0;
                sq_r     <= ~sq_r;
                tick_r   <= 1'b1;
                act_note <= req;
            end else begin
                cnt      <= cnt + CNT_W'(1);
                tick_r   <= 1'b0;
            end
        end
    end

    logic [LVL_W-1:0] mix;
    logic [LVL_W-1:0] target;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] pwm_cnt;

    // Count of channels currently high, scaled by volume.
    always_comb begin
        mix = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            mix = mix + LVL_W'(sq[i]);
        target = mix * LVL_W'(vol);
    end

    // PWM carrier; duty only reloads at the carrier wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            level   <= '0;
            speaker <= 1'b0;
        end else begin
            speaker <= (pwm_cnt < level);
            if (pwm_cnt == LVL_W'(LMAX - 1)) begin
                pwm_cnt <= '0;
                level   <= target;
            end else begin
                pwm_cnt <= pwm_cnt + LVL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: a time-stamp model of the channels plus a
// cycle-position model of the PWM carrier, compared every cycle, with
// directed literal checks on tone periods, duty and reset behaviour.
module tb_tone_synth;

    localparam int NUM_CH    = 2;
    localparam int NOTE_W    = 5;
    localparam int NUM_NOTES = 22;
    localparam int VOL_W     = 3;
    localparam int HPO       = 4;
    localparam int LMAX      = NUM_CH * ((1 << VOL_W) - 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH*NOTE_W-1:0] note = '0;
    logic [VOL_W-1:0]         vol = '0;
    logic [NUM_CH-1:0]        tick;
    logic [NUM_CH-1:0]        active;
    logic                     speaker;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    tone_synth #(
        .NUM_CH(NUM_CH),
        .NOTE_W(NOTE_W),
        .NUM_NOTES(NUM_NOTES),
        .CNT_W(32),
        .VOL_W(VOL_W),
        .HP_OVERRIDE(HPO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .note(note),
        .vol(vol),
        .tick(tick),
        .active(active),
        .speaker(speaker)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel holds a note and the absolute edge
    // number at which its current half-period ends.
    int m_note[NUM_CH];
    int m_dead[NUM_CH];
    int m_sq[NUM_CH];
    int m_tick[NUM_CH];
    int m_level = 0;
    int m_spk = 0;
    int cyc = 0;
    int m_pos, m_mix;

    function automatic int eff(input int n);
        return (n < NUM_NOTES) ? n : 0;
    endfunction

    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_note[k] = 0; m_dead[k] = 0; m_sq[k] = 0; m_tick[k] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_note[k] = 0; m_dead[k] = 0; m_sq[k] = 0; m_tick[k] = 0;
            end
            m_level = 0;
            m_spk = 0;
            cyc = 0;
        end else begin
            m_pos = cyc % LMAX;
            m_mix = 0;
            for (int k = 0; k < NUM_CH; k++) m_mix += m_sq[k];
            m_spk = (m_pos < m_level) ? 1 : 0;
            if (m_pos == LMAX - 1) m_level = m_mix * int'(vol);
            cyc++;
            for (int k = 0; k < NUM_CH; k++) begin
                if (m_note[k] == 0) begin
                    m_sq[k] = 0;
                    m_tick[k] = 0;
                    m_note[k] = eff(int'(note[k*NOTE_W +: NOTE_W]));
                    m_dead[k] = cyc + HPO * m_note[k];
                end else if (cyc == m_dead[k]) begin
                    m_sq[k] = 1 - m_sq[k];
                    m_tick[k] = 1;
                    m_note[k] = eff(int'(note[k*NOTE_W +: NOTE_W]));
                    m_dead[k] = cyc + HPO * m_note[k];
                end else begin
                    m_tick[k] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tick", int'(tick), m_tick[1] * 2 + m_tick[0]);
            check("active", int'(active), ((m_note[1] != 0) ? 2 : 0) + ((m_note[0] != 0) ? 1 : 0));
            check("speaker", int'(speaker), m_spk);
        end
    end

    task automatic wait_tick(input int k, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[k] && n < budget);
    endtask

    task automatic count_high(input int len, output int h);
        h = 0;
        repeat (len) begin
            @(negedge clk);
            h += int'(speaker);
        end
    endtask

    task automatic do_reset(input logic [NUM_CH*NOTE_W-1:0] nt, input logic [VOL_W-1:0] v);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_active", int'(active), 0);
        check("async_rst_speaker", int'(speaker), 0);
        @(negedge clk);
        note = nt;
        vol = v;
        rst_n = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h;
        #2;
        check("reset_tick", int'(tick), 0);
        check("reset_active", int'(active), 0);
        check("reset_speaker", int'(speaker), 0);
        chk_en = 1'b1;

        // Note 3 from reset: HP = 12.
        note = {5'd0, 5'd3};
        vol = 3'd7;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("active_after_release", int'(active), 1);
        wait_tick(0, 100, n); check("first_tick_latency", n, 12);
        wait_tick(0, 100, n); check("hp_note3", n, 12);

        // 3 -> 5 five cycles into a half-period.
        repeat (5) @(negedge clk);
        note[4:0] = 5'd5;
        wait_tick(0, 100, n); check("finish_old_half", n, 7);
        wait_tick(0, 100, n); check("hp_note5_a", n, 20);
        wait_tick(0, 100, n); check("hp_note5_b", n, 20);

        // 5 -> rest mid half-period.
        repeat (5) @(negedge clk);
        note[4:0] = 5'd0;
        wait_tick(0, 100, n); check("rest_at_boundary", n, 15);
        check("active_rest", int'(active[0]), 0);
        repeat (30) @(negedge clk);
        count_high(28, h); check("speaker_rest", h, 0);

        // Both channels high at full volume: level = LMAX.
        do_reset({5'd21, 5'd21}, 3'd7);
        wait_tick(0, 200, n); check("tick_note21", n, 85);
        repeat (16) @(negedge clk);
        count_high(40, h); check("both_high_const", h, 40);

        // One channel high; volume changes mid carrier.
        do_reset({5'd0, 5'd21}, 3'd7);
        wait_tick(0, 200, n); check("restart_after_reset", n, 85);
        repeat (16) @(negedge clk);
        count_high(14, h); check("one_high_vol7", h, 7);
        vol = 3'd2;
        repeat (16) @(negedge clk);
        count_high(14, h); check("one_high_vol2", h, 2);
        vol = 3'd0;
        repeat (16) @(negedge clk);
        count_high(14, h); check("vol_mute", h, 0);

        // Reset while playing, restart with note 3.
        do_reset({5'd0, 5'd3}, 3'd7);
        wait_tick(0, 100, n); check("restart_note3", n, 13);

        // Out-of-range code plays as rest.
        do_reset({5'd0, 5'd25}, 3'd7);
        repeat (5) @(negedge clk);
        check("invalid_code_rest", int'(active), 0);

        // Randomized notes, volume and occasional mid-cycle resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) note[4:0] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 39) == 0) note[9:5] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) vol = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Parametrised multi-channel successor to the single-channel buzzer.
- Generates NUM_CH independent square-wave tones from the shared note table in const.v.
- Applies note changes glitch-free, only on half-period boundaries.
- Mixes channels with a global volume into one PWM speaker output for the piano top level.

Parameters:
- NUM_CH, 2, number of tone channels (1..4).
- NOTE_W, 5, width of each channel note code.
- NUM_NOTES, 22, valid codes 0..NUM_NOTES-1; code 0 is rest.
- CNT_W, 32, width of the half-period counters.
- VOL_W, 3, width of the volume input.
- HP_OVERRIDE, 0, if nonzero, half-period of note n = HP_OVERRIDE*n cycles instead of the const.v table (simulation use).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- note  in  NUM_CH*NOTE_W  channel k note code at bits [k*NOTE_W +: NOTE_W].
- vol  in  VOL_W  global volume; 0 = mute.
- tick  out  NUM_CH  one-cycle pulse when channel k square wave toggles.
- active  out  NUM_CH  channel k currently sounding (active note nonzero).
- speaker  out  1  mixed PWM output.

Behaviour:
- Reset (async assert, sync release): all cnt=0, sq=0, act_note=0, tick=0, active=0, pwm_cnt=0, level=0, speaker=0.
- Half-period HP(n):
  - Table entry n (L1..H7 for 1..21), or HP_OVERRIDE*n when HP_OVERRIDE is set.
  - Codes >= NUM_NOTES are treated as 0 (rest).
  - HP is in clk cycles; HP values below 1 are clamped to 1.
- Per channel k, act_note is the note in effect. Each cycle:
  - If act_note==0: cnt<=0, sq<=0, act_note<=note_k (a new note starts with no delay).
  - Else if cnt==HP(act_note)-1: cnt<=0, sq<=~sq, tick_k<=1, act_note<=note_k (change applied at boundary).
  - Else: cnt<=cnt+1, tick_k<=0.
- Consequences of the per-channel rules:
  - The sounding note holds each half-period for exactly HP cycles; the full period is 2*HP.
  - A note change mid half-period completes the current half-period at the old pitch.
  - Changing to rest stops the channel at the next boundary; sq may be left at 1. Forcing sq<=0 happens on the following cycle via the act_note==0 rule.
  - Same note re-asserted: no effect, no phase reset.
  - active_k = (act_note!=0), registered with act_note.
- Mixer:
  - mix = number of channels with sq=1 (0..NUM_CH).
  - target = mix*vol.
  - LMAX = NUM_CH*(2^VOL_W-1).
- PWM carrier:
  - pwm_cnt counts 0..LMAX-1 and wraps.
  - level is latched from target only when pwm_cnt==LMAX-1, so it applies from the next carrier cycle; no mid-carrier duty change.
  - speaker <= (pwm_cnt < level), registered; one cycle latency after pwm_cnt.
  - level==LMAX gives constant 1; level==0 gives constant 0.
- Width rules: mix and target use unsigned arithmetic sized to hold LMAX; no overflow is possible.
- Simultaneous events: all channels update independently in the same cycle; a tick on several channels in one cycle is legal.
- Reset mid-note: immediate silence and all state cleared; after release, channels restart from the note inputs, starting with act_note==0.

Test Plan:
- HP_OVERRIDE=4, NUM_CH=1, vol=7, note=3 from reset -> act_note=3 one cycle after release; sq toggles every 12 cycles (24-cycle period); tick pulses every 12 cycles; active=1.
- note 3->5 applied 5 cycles into a half-period -> remaining 7 cycles at HP 12, then half-periods of 20 cycles; no shortened or extended half-period.
- note 3->0 mid half-period -> toggle at boundary, sq=0 one cycle later, active=0, speaker stays 0 after the next carrier wrap.
- NUM_CH=2, VOL_W=3, vol=7, both channels high -> level=14=LMAX, speaker constantly 1; one channel high -> speaker high 7 of 14 cycles per carrier.
- vol changed 7->2 mid carrier -> duty unchanged until the pwm_cnt==13 wrap, then 2 high cycles per 14 with one channel high; vol=0 -> speaker 0.
- Assert rst_n=0 asynchronously mid-cycle while playing -> all outputs 0 immediately without a clock edge; after release, playback resumes from cnt=0.
